drum_speed_ramp: RTL and testbench

- Downstream of the main washing-machine controller. Consumes its 11-bit drum_motor target speed in rpm and produces the actual motor speed command.
- Ramps that command up and down in bounded steps on a divided tick, instead of jumping to the target.
- Monitors the vibration sensor during spin and performs a controlled ramp-down and latched fault when vibration persists.

---
 rtl/drum_speed_ramp.sv | 206 ++++++++++++++++++++
 tb/tb_drum_speed_ramp.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_speed_ramp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : drum_speed_ramp                                                    |
// | Ramps the drum motor command toward the clamped target on a divided tick   |
// | and brakes to a latched fault on persistent spin vibration.                |
// | Option : DRUM_REBALANCE_EN adds a one-shot rebalance retry before faulting.|
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module drum_speed_ramp #(
  parameter int TICK_DIV   = 1000,
  parameter int RAMP_STEP  = 50,
  parameter int BRAKE_STEP = 100,
  parameter int MAX_SPEED  = 1400,
  parameter int VIB_LIMIT  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] target_speed,
  input  logic        enable,
  input  logic        vibration_sensor,
  output logic [10:0] speed_cmd,
  output logic        at_speed,
  output logic        ramping,
  output logic        vibration_fault,
  output logic        stopped
);

  localparam int              c_TW        = $clog2(TICK_DIV);
  localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);
  localparam logic [10:0]     c_MAX       = 11'(MAX_SPEED);
  localparam logic [11:0]     c_RAMP12    = 12'(RAMP_STEP);
  localparam logic [10:0]     c_RAMP11    = 11'(RAMP_STEP);
  localparam logic [10:0]     c_BRAKE     = 11'(BRAKE_STEP);
  localparam logic [3:0]      c_VLIM      = 4'(VIB_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RAMP_UP    = 3'd1,
    S_HOLD       = 3'd2,
    S_RAMP_DOWN  = 3'd3,
    S_FAULT_DOWN = 3'd4,
    S_FAULT      = 3'd5
`ifdef DRUM_REBALANCE_EN
    , S_REBALANCE = 3'd6
`endif
  } state_t;

  state_t          r_state, w_state_n;
  logic [c_TW-1:0] r_tick_cnt;
  logic [3:0]      r_vib_cnt, w_vib_n;
  logic [10:0]     w_speed_n;
  logic            w_fault_n;
  logic            w_tick;
  logic [10:0]     w_tgt;
  logic [11:0]     w_up_sum;
  logic [10:0]     w_up_next, w_dn_sat, w_dn_next, w_brk_next;
  logic            w_vib_mon, w_vib_hit;
  logic [3:0]      w_vib_inc, w_vib_cnt_new;
`ifdef DRUM_REBALANCE_EN
  logic            r_retry, w_retry_n;
  logic [1:0]      r_wait, w_wait_n;
`endif

  assign w_tick = (r_tick_cnt == c_TICK_LAST);
  assign w_tgt  = !enable ? 11'd0 : ((target_speed > c_MAX) ? c_MAX : target_speed);

  // Sum is one bit wider so a step above the top speed cannot wrap before clamping.
  assign w_up_sum   = {1'b0, speed_cmd} + c_RAMP12;
  assign w_up_next  = (w_up_sum > {1'b0, w_tgt}) ? w_tgt : w_up_sum[10:0];
  assign w_dn_sat   = (speed_cmd > c_RAMP11) ? (speed_cmd - c_RAMP11) : 11'd0;
  assign w_dn_next  = (w_dn_sat < w_tgt) ? w_tgt : w_dn_sat;
  assign w_brk_next = (speed_cmd > c_BRAKE) ? (speed_cmd - c_BRAKE) : 11'd0;

  assign w_vib_mon     = w_tick && ((r_state == S_RAMP_UP) || (r_state == S_HOLD))
                         && (speed_cmd != 11'd0);
  assign w_vib_inc     = (r_vib_cnt == 4'd15) ? 4'd15 : (r_vib_cnt + 4'd1);
  assign w_vib_cnt_new = vibration_sensor ? w_vib_inc : 4'd0;
  assign w_vib_hit     = w_vib_mon && (w_vib_cnt_new >= c_VLIM);

  always_comb begin
    w_state_n = r_state;
    w_speed_n = speed_cmd;
    w_vib_n   = r_vib_cnt;
    w_fault_n = vibration_fault;
`ifdef DRUM_REBALANCE_EN
    w_retry_n = r_retry;
    w_wait_n  = r_wait;
`endif
    if (w_vib_mon) begin
      w_vib_n = w_vib_cnt_new;
    end
    // A vibration limit hit overrides any target change on the same tick.
    if (w_vib_hit) begin
      w_vib_n = 4'd0;
`ifdef DRUM_REBALANCE_EN
      if (!r_retry) begin
        w_state_n = S_REBALANCE;
        w_retry_n = 1'b1;
        w_wait_n  = 2'd0;
      end else
`endif
      begin
        w_state_n = S_FAULT_DOWN;
        w_fault_n = 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          w_speed_n = 11'd0;
          w_vib_n   = 4'd0;
`ifdef DRUM_REBALANCE_EN
          w_retry_n = 1'b0;
`endif
          if (w_tgt != 11'd0) w_state_n = S_RAMP_UP;
        end
        S_RAMP_UP: begin
          if (w_tgt < speed_cmd) begin
            w_state_n = S_RAMP_DOWN;
          end else if (w_tick) begin
            w_speed_n = w_up_next;
            if (w_up_next == w_tgt) w_state_n = S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_tgt > speed_cmd)                               w_state_n = S_RAMP_UP;
          else if (w_tgt < speed_cmd)                          w_state_n = S_RAMP_DOWN;
          else if ((w_tgt == 11'd0) && (speed_cmd == 11'd0))   w_state_n = S_IDLE;
        end
        S_RAMP_DOWN: begin
          w_vib_n = 4'd0;
          if (w_tgt > speed_cmd) begin
            w_state_n = S_RAMP_UP;
          end else if (w_tick) begin
            w_speed_n = w_dn_next;
            if (w_dn_next == w_tgt) w_state_n = (w_tgt == 11'd0) ? S_IDLE : S_HOLD;
          end
        end
        S_FAULT_DOWN: begin
          w_fault_n = 1'b1;
          if (w_tick) begin
            w_speed_n = w_brk_next;
            if (w_brk_next == 11'd0) w_state_n = S_FAULT;
          end
        end
        S_FAULT: begin
          w_speed_n = 11'd0;
          w_fault_n = 1'b1;
          if (w_tick && !enable) begin
            w_state_n = S_IDLE;
            w_fault_n = 1'b0;
          end
        end
`ifdef DRUM_REBALANCE_EN
        S_REBALANCE: begin
          if (w_tick) begin
            if (speed_cmd != 11'd0) begin
              w_speed_n = w_brk_next;
            end else if (r_wait == 2'd3) begin
              w_wait_n  = 2'd0;
              w_state_n = S_RAMP_UP;
            end else begin
              w_wait_n = r_wait + 2'd1;
            end
          end
        end
`endif
        default: begin
          w_state_n = S_IDLE;
          w_speed_n = 11'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_tick_cnt      <= '0;
      r_vib_cnt       <= 4'd0;
      speed_cmd       <= 11'd0;
      at_speed        <= 1'b0;
      ramping         <= 1'b0;
      vibration_fault <= 1'b0;
      stopped         <= 1'b1;
`ifdef DRUM_REBALANCE_EN
      r_retry         <= 1'b0;
      r_wait          <= 2'd0;
`endif
    end else begin
      r_tick_cnt      <= w_tick ? '0 : (r_tick_cnt + c_TW'(1));
      r_state         <= w_state_n;
      r_vib_cnt       <= w_vib_n;
      speed_cmd       <= w_speed_n;
      at_speed        <= (w_state_n == S_HOLD) && (w_speed_n == w_tgt);
      ramping         <= (w_state_n == S_RAMP_UP) || (w_state_n == S_RAMP_DOWN);
      vibration_fault <= w_fault_n;
      stopped         <= (w_speed_n == 11'd0);
`ifdef DRUM_REBALANCE_EN
      r_retry         <= w_retry_n;
      r_wait          <= w_wait_n;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_drum_speed_ramp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_drum_speed_ramp                                                 |
// | Directed and randomized bench for drum_speed_ramp against a cycle model.   |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_drum_speed_ramp;

  localparam int TD = 4;
  localparam int RS = 50;
  localparam int BS = 100;
  localparam int MX = 1400;
  localparam int VL = 3;

  localparam int P_IDLE = 0, P_UP = 1, P_HOLD = 2, P_DOWN = 3, P_BRAKE = 4, P_FAULT = 5, P_REBAL = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] target_speed = 11'd0;
  logic        enable = 1'b0;
  logic        vibration_sensor = 1'b0;
  logic [10:0] speed_cmd;
  logic        at_speed, ramping, vibration_fault, stopped;

  int n_checks = 0;
  int n_errors = 0;

  int m_tc, m_speed, m_ph, m_vc, m_fault, m_retry, m_wait, m_at, m_ramp;

  always #5 clk = ~clk;

  drum_speed_ramp #(
    .TICK_DIV  (TD),
    .RAMP_STEP (RS),
    .BRAKE_STEP(BS),
    .MAX_SPEED (MX),
    .VIB_LIMIT (VL)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .target_speed    (target_speed),
    .enable          (enable),
    .vibration_sensor(vibration_sensor),
    .speed_cmd       (speed_cmd),
    .at_speed        (at_speed),
    .ramping         (ramping),
    .vibration_fault (vibration_fault),
    .stopped         (stopped)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 30) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_tc = 0; m_speed = 0; m_ph = P_IDLE; m_vc = 0; m_fault = 0;
    m_retry = 0; m_wait = 0; m_at = 0; m_ramp = 0;
  endtask

  // Reference behaviour for one clock edge, from the current input values.
  task automatic model_step();
    int tgt;
    bit tick, hit;
    tgt  = enable ? ((int'(target_speed) > MX) ? MX : int'(target_speed)) : 0;
    tick = (m_tc == TD - 1);
    m_tc = (m_tc + 1) % TD;
    hit  = 0;
    if (tick && (m_ph == P_UP || m_ph == P_HOLD) && m_speed > 0) begin
      m_vc = vibration_sensor ? ((m_vc < 15) ? m_vc + 1 : 15) : 0;
      if (m_vc >= VL) begin hit = 1; m_vc = 0; end
    end
    if (hit) begin
`ifdef DRUM_REBALANCE_EN
      if (m_retry == 0) begin m_ph = P_REBAL; m_retry = 1; m_wait = 0; end else
`endif
      begin m_ph = P_BRAKE; m_fault = 1; end
    end else begin
      case (m_ph)
        P_IDLE: begin
          m_speed = 0; m_vc = 0; m_retry = 0;
          if (tgt > 0) m_ph = P_UP;
        end
        P_UP: begin
          if (tgt < m_speed) m_ph = P_DOWN;
          else if (tick) begin
            m_speed = (m_speed + RS > tgt) ? tgt : m_speed + RS;
            if (m_speed == tgt) m_ph = P_HOLD;
          end
        end
        P_HOLD: begin
          if (tgt > m_speed) m_ph = P_UP;
          else if (tgt < m_speed) m_ph = P_DOWN;
          else if (tgt == 0) m_ph = P_IDLE;
        end
        P_DOWN: begin
          m_vc = 0;
          if (tgt > m_speed) m_ph = P_UP;
          else if (tick) begin
            m_speed = (m_speed - RS < tgt) ? tgt : m_speed - RS;
            if (m_speed == tgt) m_ph = (tgt == 0) ? P_IDLE : P_HOLD;
          end
        end
        P_BRAKE: begin
          if (tick) begin
            m_speed = (m_speed - BS < 0) ? 0 : m_speed - BS;
            if (m_speed == 0) m_ph = P_FAULT;
          end
        end
        P_FAULT: begin
          m_speed = 0;
          if (tick && !enable) begin m_ph = P_IDLE; m_fault = 0; end
        end
        default: begin
          if (tick) begin
            if (m_speed > 0) m_speed = (m_speed - BS < 0) ? 0 : m_speed - BS;
            else if (m_wait == 3) begin m_wait = 0; m_ph = P_UP; end
            else m_wait++;
          end
        end
      endcase
    end
    m_at   = (m_ph == P_HOLD && m_speed == tgt) ? 1 : 0;
    m_ramp = (m_ph == P_UP || m_ph == P_DOWN) ? 1 : 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("speed_cmd", speed_cmd, m_speed);
    check("at_speed", at_speed, m_at);
    check("ramping", ramping, m_ramp);
    check("vibration_fault", vibration_fault, m_fault);
    check("stopped", stopped, (m_speed == 0) ? 1 : 0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_speed", speed_cmd, 0);
    check("rst_stopped", stopped, 1);
    check("rst_flags", {at_speed, ramping, vibration_fault}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dn120[6];
    dn120 = '{350, 300, 250, 200, 150, 120};
    do_reset();

    // Ramp to 400, one step per four-cycle tick block.
    enable = 1'b1; target_speed = 11'd400;
    for (int k = 0; k < 8; k++) begin
      cycles(4);
      check("ramp_up_step", speed_cmd, 50 * (k + 1));
      check("ramp_up_ramping", ramping, (k < 7) ? 1 : 0);
    end
    check("hold400_at_speed", at_speed, 1);

    target_speed = 11'd120;
    for (int k = 0; k < 6; k++) begin
      cycles(4);
      check("ramp_down_step", speed_cmd, dn120[k]);
    end
    check("hold120_at_speed", at_speed, 1);

    target_speed = 11'd2000;
    cycles(4 * 30);
    check("clamp_1400", speed_cmd, 1400);
    check("clamp_at_speed", at_speed, 1);

    target_speed = 11'd800;
    cycles(4 * 13);
    check("hold800", speed_cmd, 800);

`ifdef DRUM_REBALANCE_EN
    vibration_sensor = 1'b1;
    cycles(4 * 3);
    check("rebal_no_fault", vibration_fault, 0);
    vibration_sensor = 1'b0;
    cycles(4 * 12);
    check("rebal_at_zero", speed_cmd, 0);
    cycles(4 * 16);
    check("rebal_back_800", speed_cmd, 800);
    check("rebal_fault_low", vibration_fault, 0);
`endif

    vibration_sensor = 1'b1;
    cycles(4 * 3);
    check("vib_fault_set", vibration_fault, 1);
    vibration_sensor = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycles(4);
      check("brake_step", speed_cmd, 700 - 100 * k);
    end
    cycles(4);
    check("fault_latched", vibration_fault, 1);
    enable = 1'b0;
    cycles(4);
    check("fault_cleared", vibration_fault, 0);
    check("fault_clear_stopped", stopped, 1);

    enable = 1'b1;
    cycles(4 * 17);
    check("reramp_800", speed_cmd, 800);
    vibration_sensor = 1'b1; cycles(8);
    vibration_sensor = 1'b0; cycles(4);
    vibration_sensor = 1'b1; cycles(8);
    vibration_sensor = 1'b0; cycles(4);
    check("vib_2_0_2_no_fault", vibration_fault, 0);
    check("vib_2_0_2_speed", speed_cmd, 800);

    // Asynchronous reset in the middle of a ramp.
    do_reset();
    target_speed = 11'd400;
    for (int i = 0; i < 200 && m_speed != 250; i++) cycle();
    check("reach_250", speed_cmd, 250);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("async_rst_speed", speed_cmd, 0);
    check("async_rst_stopped", stopped, 1);
    check("async_rst_ramping", ramping, 0);
    do_reset();

    // Randomized segments.
    for (int s = 0; s < 400; s++) begin
      case ($urandom_range(0, 9))
        0:       target_speed = 11'd0;
        1, 2:    target_speed = 11'($urandom_range(1401, 2047));
        default: target_speed = 11'($urandom_range(0, 1400));
      endcase
      enable           = ($urandom_range(0, 7) != 0);
      vibration_sensor = ($urandom_range(0, 3) == 0);
      cycles($urandom_range(1, 12));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
